sram_like_queue: RTL

Parametrised SRAM-like bus master front end that supports up to DEPTH in-flight transactions. It generalises the single-outstanding handshake-plus-rdata-latch pair used by the fetch and memory stages. It sits between a pipeline stage (instruction fetch or memory access) and the SRAM-like inst/data port. It tracks outstanding requests in issue order, returns responses to the stage, and discards responses for transactions the pipeline has flushed.

---
 rtl/sram_like_queue_if.sv | 25 ++
 rtl/sram_like_queue.sv | 85 ++++++++
 2 files changed

// File: rtl/sram_like_queue_if.sv
// SRAM-like inst/data port: one request channel (req/addr_ok) and one response channel (data_ok/rdata).
// The master drives request fields; the slave answers with addr_ok and data_ok/rdata.
interface sram_like_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_queue.sv
// Multi-outstanding SRAM-like master front end: tracks in-flight transactions in issue
// order, returns live responses to the pipeline stage and drops those killed by a flush.
module sram_like_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  input  logic              cpu_flush,
  output logic              cpu_resp,
  output logic              cpu_resp_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              busy,
  output logic              proto_err,
  sram_like_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a request transfers on a cycle where req && addr_ok; a response
  // transfers on every cycle data_ok is high (no back-pressure on responses).
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [DEPTH-1:0] killed_q;
  logic [DEPTH-1:0] wr_q;

  logic full;
  logic accept;
  logic pop;
  logic head_live;

  assign full      = (count == CNT_W'(DEPTH));
  assign bus.req   = cpu_req & ~full & ~cpu_flush;
  assign bus.wr    = cpu_wr;
  assign bus.size  = cpu_size;
  assign bus.addr  = cpu_addr;
  assign bus.wdata = cpu_wdata;
  assign accept    = bus.req & bus.addr_ok;
  assign cpu_ready = accept;
  assign pop       = bus.data_ok & (count != '0);
  // A flush in the same cycle as the pop also kills the head.
  assign head_live = ~killed_q[head] & ~cpu_flush;
  assign busy      = (count != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      killed_q    <= '0;
      wr_q        <= '0;
      cpu_resp    <= 1'b0;
      cpu_resp_wr <= 1'b0;
      cpu_rdata   <= '0;
      proto_err   <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (accept) tail <= tail + PTR_W'(1);
      if (pop)    head <= head + PTR_W'(1);
      // Free slots may be marked killed too; a push always clears its own slot,
      // and no push can happen in a flush cycle.
      if (cpu_flush) killed_q <= '1;
      if (accept) begin
        killed_q[tail] <= 1'b0;
        wr_q[tail]     <= cpu_wr;
      end
      cpu_resp    <= pop & head_live;
      cpu_resp_wr <= pop & head_live & wr_q[head];
      if (pop && head_live && !wr_q[head]) cpu_rdata <= bus.rdata;
      if (bus.data_ok && count == '0) proto_err <= 1'b1;
    end
  end
endmodule
